// File: rtl/arrow_wave_scheduler.sv
// Arrow wave scheduler: picks a wave pattern from the turn number, spawns arrows into free
// sprite slots on frame ticks, and pulses finished once every spawned arrow has retired.
// Define ARROW_WAVE_TIMEOUT_EN to add a drain watchdog that force-retires stuck arrows.
module arrow_wave_scheduler #(
  parameter int NUM_SLOTS      = 8,
  parameter int BASE_INTERVAL  = 30,
  parameter int MIN_INTERVAL   = 8,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick_in,
  input  logic                         start_in,
  input  logic [3:0]                   turn_in,
  input  logic [NUM_SLOTS-1:0]         slot_done_in,
  output logic                         busy_out,
  output logic                         finished_out,
  output logic                         spawn_valid_out,
  output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot_out,
  output logic [1:0]                   spawn_direction_out,
  output logic [1:0]                   spawn_speed_out,
  output logic                         spawn_inversed_out,
  output logic [NUM_SLOTS-1:0]         slot_active_out,
  output logic [4:0]                   spawned_count_out
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [7:0] BASE_8 = 8'(BASE_INTERVAL);
  localparam logic [7:0] MIN_8  = 8'(MIN_INTERVAL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_SPAWN = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [3:0]           r_turn;
  logic [4:0]           r_total;
  logic [7:0]           r_interval;
  logic [1:0]           r_speed;
  logic [7:0]           r_frame_cnt;
  logic [4:0]           r_spawned;
  logic [NUM_SLOTS-1:0] r_slot_active;

  logic                 r_busy;
  logic                 r_finished;
  logic                 r_spawn_valid;
  logic [SLOT_W-1:0]    r_spawn_slot;
  logic [1:0]           r_spawn_dir;
  logic [1:0]           r_spawn_speed;
  logic                 r_spawn_inv;

  logic [7:0]           w_turn_x2;
  logic [7:0]           w_raw_interval;
  logic [7:0]           w_interval;
  logic [4:0]           w_total;
  logic [7:0]           w_interval_m1;
  logic                 w_free_found;
  logic [SLOT_W-1:0]    w_free_idx;
  logic                 w_do_spawn;
  logic [NUM_SLOTS-1:0] w_set_mask;
  logic                 w_last_spawn;
  logic                 w_timeout;

  // Pattern from the live turn input; only consumed in LOAD. Clamp guards 8-bit underflow.
  assign w_turn_x2      = {3'b000, turn_in, 1'b0};
  assign w_raw_interval = BASE_8 - w_turn_x2;
  assign w_interval     = ((w_turn_x2 >= BASE_8) || (w_raw_interval < MIN_8)) ? MIN_8 : w_raw_interval;
  assign w_total        = 5'd8 + {1'b0, turn_in[2:0], 1'b0};
  assign w_interval_m1  = r_interval - 8'd1;

  // Lowest-index free slot, taken from the registered mask.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_slot_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SLOT_W'(i);
      end
    end
  end

  assign w_do_spawn   = (r_state == S_SPAWN) && w_free_found;
  assign w_set_mask   = w_do_spawn ? (NUM_SLOTS'(1) << w_free_idx) : '0;
  assign w_last_spawn = ((r_spawned + 5'd1) == r_total);

`ifdef ARROW_WAVE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_FRAMES - 1);
  logic [15:0] r_drain_cnt;

  assign w_timeout = (r_state == S_DRAIN) && frame_tick_in && (r_drain_cnt == TIMEOUT_LAST);

  // Held at zero outside DRAIN so the count always starts from DRAIN entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (r_state != S_DRAIN) begin
      r_drain_cnt <= '0;
    end else if (frame_tick_in) begin
      r_drain_cnt <= r_drain_cnt + 16'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_FRAMES != 0);
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_WAIT;
      S_WAIT:  if (frame_tick_in && (r_frame_cnt == w_interval_m1)) w_next_state = S_SPAWN;
      S_SPAWN: begin
        if (w_do_spawn) w_next_state = w_last_spawn ? S_DRAIN : S_WAIT;
      end
      S_DRAIN: if ((r_slot_active == '0) || w_timeout) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_finished    <= 1'b0;
      r_spawn_valid <= 1'b0;
      r_spawn_slot  <= '0;
      r_spawn_dir   <= '0;
      r_spawn_speed <= '0;
      r_spawn_inv   <= 1'b0;
      r_slot_active <= '0;
    end else begin
      r_state       <= w_next_state;
      r_busy        <= (w_next_state != S_IDLE);
      r_finished    <= (w_next_state == S_DONE);
      r_spawn_valid <= w_do_spawn;
      r_spawn_slot  <= w_do_spawn ? w_free_idx : '0;
      r_spawn_dir   <= w_do_spawn ? (r_spawned[1:0] + r_turn[1:0]) : 2'b00;
      r_spawn_speed <= w_do_spawn ? r_speed : 2'b00;
      r_spawn_inv   <= w_do_spawn & r_turn[0] & r_spawned[0];
      // Retire clears are ORed with the new spawn bit; the two never hit the same slot.
      if (w_timeout) begin
        r_slot_active <= '0;
      end else begin
        r_slot_active <= (r_slot_active & ~slot_done_in) | w_set_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_turn      <= '0;
      r_total     <= '0;
      r_interval  <= '0;
      r_speed     <= '0;
      r_frame_cnt <= '0;
      r_spawned   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_turn      <= turn_in;
          r_total     <= w_total;
          r_interval  <= w_interval;
          r_speed     <= turn_in[3:2];
          r_frame_cnt <= w_interval - 8'd1;
          r_spawned   <= '0;
        end
        S_WAIT: begin
          if (frame_tick_in) begin
            r_frame_cnt <= (r_frame_cnt == w_interval_m1) ? 8'd0 : (r_frame_cnt + 8'd1);
          end
        end
        S_SPAWN: begin
          if (w_do_spawn) r_spawned <= r_spawned + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_out            = r_busy;
  assign finished_out        = r_finished;
  assign spawn_valid_out     = r_spawn_valid;
  assign spawn_slot_out      = r_spawn_slot;
  assign spawn_direction_out = r_spawn_dir;
  assign spawn_speed_out     = r_spawn_speed;
  assign spawn_inversed_out  = r_spawn_inv;
  assign slot_active_out     = r_slot_active;
  assign spawned_count_out   = r_spawned;

endmodule
